// File: rtl/aes_pkg.sv
// Shared AES arithmetic: S-box tables, Rcon, GF(2^8) helpers and 32-bit column/word helpers.
// Byte i of a 128-bit block sits at bits [127-8i -: 8] (FIPS-197 order).
package aes_pkg;

  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSboxTab = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTab[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTab[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir_i=0) or inverse (dir_i=1).
module aes_key_step
  import aes_pkg::*;
(
  input  logic         dir_i,
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] g;

  assign {w0, w1, w2, w3} = rk_i;

  // Both directions share one SubWord; only its source word differs.
  assign g = sub_word(rot_word(dir_i ? (w3 ^ w2) : w3)) ^ {rcon_i, 24'h000000};

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    if (!dir_i) begin
      n0 = w0 ^ g;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ g;
    end
  end

  assign rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_inv.sv
// Iterative AES-128 inverse cipher, one column per cycle; derives round key 10 on-chip.
module aes128_inv
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out,
  output logic         done
);

  typedef enum logic [2:0] {StIdle, StExpand, StInit, StRound, StDone} st_e;

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] rk_q, rk_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [127:0] data_out_q, data_out_d;

  logic [1:0]   col;
  logic [3:0]   rnd;
  logic [31:0]  isb_col;
  logic [31:0]  ark_col;
  logic [31:0]  col_res;
  logic         ks_dir;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_out;

  assign col = cnt_q[1:0];
  assign rnd = cnt_q[5:2];

  // Column c of InvShiftRows: row r byte comes from column (c - r) mod 4.
  always_comb begin
    isb_col = '0;
    for (int row = 0; row < 4; row++) begin
      logic [1:0] src;
      int         idx;
      src = col - 2'(row);
      idx = row + 4 * int'(src);
      isb_col[8*(3-row) +: 8] = inv_sbox(state_q[8*(15-idx) +: 8]);
    end
  end

  assign ark_col = isb_col ^ rk_q[32*(3-int'(col)) +: 32];
  assign col_res = (rnd != 4'd0) ? inv_mix_col(ark_col) : ark_col;

  aes_key_step u_key_step (
    .dir_i  (ks_dir),
    .rk_i   (rk_q),
    .rcon_i (ks_rcon),
    .rk_o   (ks_out)
  );

  always_comb begin
    st_d       = st_q;
    state_d    = state_q;
    acc_d      = acc_q;
    rk_d       = rk_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    ks_dir     = 1'b1;
    ks_rcon    = rcon(rnd);
    unique case (st_q)
      StExpand: begin
        ks_dir  = 1'b0;
        ks_rcon = rcon(cnt_q[3:0] + 4'd1);
        rk_d    = ks_out;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd9) st_d = StInit;
      end
      StInit: begin
        state_d = state_q ^ rk_q;
        ks_rcon = rcon(4'd10);
        rk_d    = ks_out;
        cnt_d   = 6'd36;
        st_d    = StRound;
      end
      StRound: begin
        acc_d[32*(3-int'(col)) +: 32] = col_res;
        if (col == 2'd3) begin
          // Last column bypasses acc so the round completes on this edge.
          state_d = {acc_q[127:32], col_res};
          if (rnd != 4'd0) begin
            rk_d  = ks_out;
            cnt_d = cnt_q - 6'd7;
          end else begin
            data_out_d = {acc_q[127:32], col_res};
            done_d     = 1'b1;
            st_d       = StDone;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q     <= 1'b0;
      data_out_q <= '0;
      if (ce) begin
        st_q    <= StExpand;
        state_q <= data_in;
        rk_q    <= key;
        cnt_q   <= 6'd0;
      end else begin
        st_q <= StIdle;
      end
    end else if (ce) begin
      st_q       <= st_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      rk_q       <= rk_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes128_inv.sv
// Directed bench for aes128_inv using FIPS-197 vectors, ce gating, abort and idle cases.
module tb_aes128_inv;

  localparam logic [127:0] C1Key  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] BKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BRk10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] One    = 128'h1;
  localparam logic [127:0] Zero   = 128'h0;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ce = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic [127:0] data_out;
  logic         done;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  aes128_inv dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .done     (done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Applies reset+ce with the given vector; returns just after edge 0.
  task automatic start(input logic [127:0] k, input logic [127:0] ct);
    key     = k;
    data_in = ct;
    reset   = 1'b1;
    ce      = 1'b1;
    tick();
    reset   = 1'b0;
  endtask

  initial begin
    // C.1 with ce high; inputs scrambled after start to show they are not resampled.
    start(C1Key, C1Ct);
    chk("c1_rst_done", {127'b0, done}, Zero);
    chk("c1_rst_dout", data_out, Zero);
    data_in = 128'hdeadbeef_00000000_cafef00d_12345678;
    key     = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    repeat (10) tick();
    chk("c1_rk10", dut.rk_q, C1Rk10);
    repeat (40) tick();
    chk("c1_done_e50", {127'b0, done}, Zero);
    chk("c1_dout_e50", data_out, Zero);
    tick();
    chk("c1_done_e51", {127'b0, done}, One);
    chk("c1_pt", data_out, C1Pt);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c1_hold_done", {127'b0, done}, One);
      chk("c1_hold_pt", data_out, C1Pt);
    end

    // App. B vector.
    start(BKey, BCt);
    chk("b_rst_done", {127'b0, done}, Zero);
    repeat (10) tick();
    chk("b_rk10", dut.rk_q, BRk10);
    repeat (40) tick();
    chk("b_done_e50", {127'b0, done}, Zero);
    tick();
    chk("b_done_e51", {127'b0, done}, One);
    chk("b_pt", data_out, BPt);

    // C.1 with ce toggling: done must follow the 51st enabled edge exactly.
    start(C1Key, C1Ct);
    for (int k = 1; k <= 51; k++) begin
      ce = 1'b0;
      tick();
      chk("gap_done", {127'b0, done}, Zero);
      chk("gap_dout", data_out, Zero);
      ce = 1'b1;
      tick();
      chk("ce_done", {127'b0, done}, (k == 51) ? One : Zero);
    end
    chk("ce_pt", data_out, C1Pt);
    ce = 1'b0;
    repeat (3) tick();
    chk("ce_low_done", {127'b0, done}, One);
    chk("ce_low_pt", data_out, C1Pt);
    ce = 1'b1;

    // Abort C.1 at edge 20 with the App. B vector.
    start(C1Key, C1Ct);
    repeat (19) tick();
    key     = BKey;
    data_in = BCt;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      chk("abort_done_low", {127'b0, done}, Zero);
    end
    tick();
    chk("abort_done", {127'b0, done}, One);
    chk("abort_pt", data_out, BPt);

    // Reset with ce low idles the core; ce alone cannot restart it.
    reset = 1'b1;
    ce    = 1'b0;
    tick();
    reset = 1'b0;
    chk("idle_rst_done", {127'b0, done}, Zero);
    chk("idle_rst_dout", data_out, Zero);
    ce = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_done", {127'b0, done}, Zero);
      chk("idle_dout", data_out, Zero);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
